branch_predict_unit: RTL and testbench
======================================

Name: branch_predict_unit

Overview:
- Pipelined successor to the combinational branch comparator, for the pipelined MIPS core.
- Fetch side: a PC-indexed branch history table (BHT) of 2-bit saturating counters supplies a same-cycle taken/not-taken prediction.
- Execute side: the unit evaluates the branch condition, registers the outcome and raises mispredict one cycle later, then trains the BHT.
- It also keeps saturating branch and mispredict statistics counters.

Parameters:
WIDTH, 32, operand width of res_a/res_b (signed two's complement for sign tests)
PC_W, 32, program counter width
BHT_DEPTH, 64, number of BHT entries; power of two, >= 4
IDX_W, $clog2(BHT_DEPTH), BHT index width (derived, not overridden)
STAT_W, 32, width of statistics counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
lookup_pc  in  PC_W  fetch PC to predict
pred_taken  out  1  combinational prediction for lookup_pc
res_valid  in  1  resolve request this cycle
res_pc  in  PC_W  PC of branch being resolved
res_type  in  3  branch type, BR_* encoding from Control_encode.vh
res_a  in  WIDTH  rs operand
res_b  in  WIDTH  rt operand
res_pred_taken  in  1  prediction that was used for this branch at fetch
done  out  1  registered pulse: resolve result valid
taken  out  1  registered actual outcome
mispredict  out  1  registered: taken != res_pred_taken
clear_stats  in  1  synchronous clear of statistics counters
branch_count  out  STAT_W  resolved real branches
mispredict_count  out  STAT_W  resolved mispredictions

Behaviour:
- Reset (rst=1 at a clk edge): every BHT entry = 2'b01 (weakly not-taken); done, taken, mispredict = 0; branch_count, mispredict_count = 0. An in-flight resolve is discarded, so no done pulse follows a reset cycle.
- Index: idx = pc[IDX_W+1:2], for both lookup and resolve. Word-aligned; bits [1:0] ignored.
- Prediction: pred_taken = BHT[idx(lookup_pc)][1]. Purely combinational, zero latency.
- Condition evaluation (combinational, in the resolve cycle):
  - BR_BEQ: a==b; BR_BNE: a!=b.
  - BR_BLEZ: signed a<=0; BR_BGTZ: signed a>0; BR_BLTZ: signed a<0; BR_BGEZ: signed a>=0.
  - BR_NONE and undefined codes: not taken.
- Latency: the outcome registers at the edge ending the res_valid cycle. done, taken and mispredict are high for exactly one cycle after it. Back-to-back res_valid gives back-to-back done pulses; there is no stall.
- Real branch = res_valid && res_type is one of the six defined branch codes.
- Non-branch resolve (res_valid with BR_NONE/undefined): done=1, taken=0, mispredict=0. No BHT update, no counter change.
- BHT update on a real branch, at the same edge the outcome registers:
  - taken: counter += 1, saturating at 2'b11.
  - not taken: counter -= 1, saturating at 2'b00.
- Same-cycle lookup and update of the same index: pred_taken shows the pre-update value (no bypass). The new value is visible from the next cycle.
- Statistics counters:
  - branch_count += 1 per real branch.
  - mispredict_count += 1 per real-branch mispredict.
  - Both saturate at all-ones and do not wrap.
  - Counters are registered outputs.
- clear_stats: zeroes both counters at the next edge and overrides an increment in the same cycle. It does not affect the BHT or done/taken/mispredict.
- res_valid=0: done=0. taken and mispredict hold 0.

Test Plan:
- Reset then lookup_pc=0x0040_0000 -> pred_taken=0; both counters=0; done=0 one cycle later.
- Resolve BR_BEQ, a=b=5, pc=0x100, res_pred_taken=0 -> next cycle done=1, taken=1, mispredict=1; branch_count=1, mispredict_count=1; lookup 0x100 then gives pred_taken=1 (01->10).
- Signed tests: BR_BLTZ a=0xFFFF_FFFF -> taken=1; BR_BGTZ a=0x8000_0000 -> taken=0; BR_BLEZ a=0 -> taken=1; BR_BGEZ a=0 -> taken=1.
- Saturation: four taken resolves at pc=0x200 -> counter 11; one not-taken -> 10, pred_taken still 1; two more not-taken -> 00; a further not-taken stays 00.
- Aliasing and hazards:
  - pc 0x104 and 0x104+4*BHT_DEPTH share an entry.
  - Same-cycle lookup and resolve at 0x300 returns the old prediction.
  - res_valid with BR_NONE -> done=1, taken=0, counters unchanged.
- Control edges:
  - rst asserted in the cycle after res_valid -> no done pulse, BHT entries back to 01.
  - clear_stats together with a mispredicting resolve -> both counters read 0.
  - STAT_W=4 bench: 20 branches -> branch_count=15.

Source files
------------

// File: rtl/branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_predict_unit
// Function : PC-indexed 2-bit BHT predictor with registered branch resolve,
//            BHT training and saturating branch/mispredict statistics.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predict_unit #(
  parameter int WIDTH     = 32,
  parameter int PC_W      = 32,
  parameter int BHT_DEPTH = 64,
  parameter int STAT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_taken,
  input  logic              res_valid,
  input  logic [PC_W-1:0]   res_pc,
  input  logic [2:0]        res_type,
  input  logic [WIDTH-1:0]  res_a,
  input  logic [WIDTH-1:0]  res_b,
  input  logic              res_pred_taken,
  output logic              done,
  output logic              taken,
  output logic              mispredict,
  input  logic              clear_stats,
  output logic [STAT_W-1:0] branch_count,
  output logic [STAT_W-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLEZ = 3'd3;
  localparam logic [2:0] BR_BGTZ = 3'd4;
  localparam logic [2:0] BR_BLTZ = 3'd5;
  localparam logic [2:0] BR_BGEZ = 3'd6;

  localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};
  localparam logic [STAT_W-1:0] STAT_ONE = STAT_W'(1);

  logic [1:0]        r_bht [BHT_DEPTH];
  logic              r_done;
  logic              r_taken;
  logic              r_mispredict;
  logic [STAT_W-1:0] r_branch_count;
  logic [STAT_W-1:0] r_mispredict_count;

  logic [IDX_W-1:0]  w_lookup_idx;
  logic [IDX_W-1:0]  w_res_idx;
  logic              w_is_branch;
  logic              w_cond;
  logic              w_real;
  logic              w_mis;
  logic              w_a_neg;
  logic              w_a_zero;
  logic              w_unused_bits;

  assign w_lookup_idx = lookup_pc[IDX_W+1:2];
  assign w_res_idx    = res_pc[IDX_W+1:2];
  assign w_unused_bits = ^{lookup_pc, res_pc};

  // Read before any same-cycle update: the trained value appears next cycle.
  assign pred_taken = r_bht[w_lookup_idx][1];

  assign w_a_neg  = res_a[WIDTH-1];
  assign w_a_zero = (res_a == '0);

  always_comb begin
    w_is_branch = 1'b1;
    w_cond      = 1'b0;
    case (res_type)
      BR_BEQ:  w_cond = (res_a == res_b);
      BR_BNE:  w_cond = (res_a != res_b);
      BR_BLEZ: w_cond = w_a_neg | w_a_zero;
      BR_BGTZ: w_cond = ~w_a_neg & ~w_a_zero;
      BR_BLTZ: w_cond = w_a_neg;
      BR_BGEZ: w_cond = ~w_a_neg;
      default: w_is_branch = 1'b0;
    endcase
  end

  assign w_real = res_valid & w_is_branch;
  assign w_mis  = w_real & (w_cond != res_pred_taken);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) begin
        r_bht[i] <= 2'b01;
      end
    end else if (w_real) begin
      if (w_cond) begin
        if (r_bht[w_res_idx] != 2'b11) r_bht[w_res_idx] <= r_bht[w_res_idx] + 2'd1;
      end else begin
        if (r_bht[w_res_idx] != 2'b00) r_bht[w_res_idx] <= r_bht[w_res_idx] - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_done       <= 1'b0;
      r_taken      <= 1'b0;
      r_mispredict <= 1'b0;
    end else begin
      r_done       <= res_valid;
      r_taken      <= w_real & w_cond;
      r_mispredict <= w_mis;
    end
  end

  // Clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (rst || clear_stats) begin
      r_branch_count     <= '0;
      r_mispredict_count <= '0;
    end else begin
      if (w_real && (r_branch_count != STAT_MAX))
        r_branch_count <= r_branch_count + STAT_ONE;
      if (w_mis && (r_mispredict_count != STAT_MAX))
        r_mispredict_count <= r_mispredict_count + STAT_ONE;
    end
  end

  assign done             = r_done;
  assign taken            = r_taken;
  assign mispredict       = r_mispredict;
  assign branch_count     = r_branch_count;
  assign mispredict_count = r_mispredict_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_predict_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_predict_unit
// Function : Directed and random stimulus against a behavioural BHT model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predict_unit;

  localparam int DEPTH = 64;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [2:0]  res_type;
  logic [31:0] res_a;
  logic [31:0] res_b;
  logic        res_pred_taken;
  logic        clear_stats;

  logic        pred_taken, done, taken, mispredict;
  logic [31:0] branch_count, mispredict_count;
  logic        pred_taken_s, done_s, taken_s, mispredict_s;
  logic [3:0]  branch_count_s, mispredict_count_s;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int     m_bht [DEPTH];
  longint m_bc, m_mc, m_bc4, m_mc4;

  branch_predict_unit dut (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_taken(pred_taken),
    .res_valid(res_valid), .res_pc(res_pc), .res_type(res_type),
    .res_a(res_a), .res_b(res_b), .res_pred_taken(res_pred_taken),
    .done(done), .taken(taken), .mispredict(mispredict),
    .clear_stats(clear_stats), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  branch_predict_unit #(.STAT_W(4)) dut_s (
    .clk(clk), .rst(rst), .lookup_pc(lookup_pc), .pred_taken(pred_taken_s),
    .res_valid(res_valid), .res_pc(res_pc), .res_type(res_type),
    .res_a(res_a), .res_b(res_b), .res_pred_taken(res_pred_taken),
    .done(done_s), .taken(taken_s), .mispredict(mispredict_s),
    .clear_stats(clear_stats), .branch_count(branch_count_s),
    .mispredict_count(mispredict_count_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction

  function automatic bit branch_outcome(input logic [2:0] t, input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = $signed(a);
    case (t)
      3'd1: return a == b;
      3'd2: return a != b;
      3'd3: return sa <= 0;
      3'd4: return sa > 0;
      3'd5: return sa < 0;
      3'd6: return sa >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic longint sat_inc(input longint v, input longint max);
    return (v >= max) ? max : v + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
    m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
  endtask

  // One clock cycle: drive, check prediction before the edge, check results after.
  task automatic step(input bit r, input bit v, input logic [31:0] pc, input logic [2:0] t,
                      input logic [31:0] a, input logic [31:0] b, input bit pt,
                      input bit clr, input logic [31:0] lpc);
    bit real_br, outc, e_done, e_taken, e_mis;
    @(negedge clk);
    rst = r; res_valid = v; res_pc = pc; res_type = t; res_a = a; res_b = b;
    res_pred_taken = pt; clear_stats = clr; lookup_pc = lpc;
    #1;
    check("pred_taken", {63'd0, pred_taken}, {63'd0, m_bht[idx_of(lpc)] >= 2});
    real_br = v && (t inside {[3'd1:3'd6]});
    outc    = real_br && branch_outcome(t, a, b);
    @(posedge clk);
    #1;
    if (r) begin
      model_reset();
      e_done = 0; e_taken = 0; e_mis = 0;
    end else begin
      e_done = v; e_taken = outc; e_mis = real_br && (outc != pt);
      if (real_br) begin
        if (outc) m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] < 3) ? m_bht[idx_of(pc)] + 1 : 3;
        else      m_bht[idx_of(pc)] = (m_bht[idx_of(pc)] > 0) ? m_bht[idx_of(pc)] - 1 : 0;
      end
      if (clr) begin
        m_bc = 0; m_mc = 0; m_bc4 = 0; m_mc4 = 0;
      end else begin
        if (real_br) begin m_bc = sat_inc(m_bc, 64'hFFFF_FFFF); m_bc4 = sat_inc(m_bc4, 15); end
        if (e_mis)   begin m_mc = sat_inc(m_mc, 64'hFFFF_FFFF); m_mc4 = sat_inc(m_mc4, 15); end
      end
    end
    check("done",        {63'd0, done},       {63'd0, e_done});
    check("taken",       {63'd0, taken},      {63'd0, e_taken});
    check("mispredict",  {63'd0, mispredict}, {63'd0, e_mis});
    check("branch_cnt",  {32'd0, branch_count},     m_bc);
    check("mispred_cnt", {32'd0, mispredict_count}, m_mc);
    check("branch_cnt4", {60'd0, branch_count_s},     m_bc4);
    check("mispred_cnt4",{60'd0, mispredict_count_s}, m_mc4);
  endtask

  task automatic peek(input string tag, input logic [31:0] lpc, input bit exp);
    lookup_pc = lpc;
    #1;
    check(tag, {63'd0, pred_taken}, {63'd0, exp});
  endtask

  initial begin
    logic [31:0] ra, rb, rpc;
    rst = 1'b1; res_valid = 0; res_pc = 0; res_type = 0; res_a = 0; res_b = 0;
    res_pred_taken = 0; clear_stats = 0; lookup_pc = 0;
    model_reset();
    repeat (2) @(posedge clk);

    // Reset state and idle cycle
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0040_0000);
    check("reset_pred", {63'd0, pred_taken}, 64'd0);

    // BEQ taken, mispredicted; entry 01 -> 10
    step(0, 1, 32'h100, 3'd1, 5, 5, 0, 0, 32'h100);
    check("beq_mis_cnt", {32'd0, mispredict_count}, 64'd1);
    peek("beq_trained", 32'h100, 1'b1);

    // Signed conditions and BNE
    step(0, 1, 32'h180, 3'd5, 32'hFFFF_FFFF, 0, 1, 0, 32'h180);
    step(0, 1, 32'h184, 3'd4, 32'h8000_0000, 0, 0, 0, 32'h184);
    step(0, 1, 32'h188, 3'd3, 0, 0, 0, 0, 32'h188);
    step(0, 1, 32'h18C, 3'd6, 0, 0, 1, 0, 32'h18C);
    step(0, 1, 32'h190, 3'd2, 3, 4, 0, 0, 32'h190);
    step(0, 1, 32'h194, 3'd4, 32'h7FFF_FFFF, 0, 1, 0, 32'h194);

    // Saturation at 0x200
    repeat (4) step(0, 1, 32'h200, 3'd1, 7, 7, 1, 0, 32'h200);
    step(0, 1, 32'h200, 3'd2, 7, 7, 1, 0, 32'h200);
    peek("sat_10_pred", 32'h200, 1'b1);
    repeat (3) step(0, 1, 32'h200, 3'd2, 7, 7, 0, 0, 32'h200);
    peek("sat_00_pred", 32'h200, 1'b0);

    // Aliasing, same-cycle hazard, non-branch resolves
    step(0, 1, 32'h104, 3'd1, 1, 1, 0, 0, 32'h104);
    peek("alias_pred", 32'h104 + 4 * DEPTH, 1'b1);
    step(0, 1, 32'h300, 3'd1, 1, 1, 0, 0, 32'h300);
    step(0, 1, 32'h300, 3'd1, 1, 1, 1, 0, 32'h300);
    step(0, 1, 32'h300, 3'd0, 1, 1, 1, 0, 32'h300);
    step(0, 1, 32'h300, 3'd7, 1, 1, 1, 0, 32'h300);

    // Reset in the cycle after a resolve, and alongside one
    step(0, 1, 32'h400, 3'd1, 2, 2, 0, 0, 32'h400);
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h400);
    step(1, 1, 32'h400, 3'd1, 2, 2, 0, 0, 32'h400);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h100);
    check("rst_no_done", {63'd0, done}, 64'd0);

    // clear_stats with a mispredicting resolve
    step(0, 1, 32'h500, 3'd1, 1, 1, 0, 0, 32'h500);
    step(0, 1, 32'h504, 3'd1, 1, 2, 1, 1, 32'h504);
    check("clr_bc", {32'd0, branch_count}, 64'd0);
    check("clr_mc", {32'd0, mispredict_count}, 64'd0);

    // Narrow counter saturation: 20 branches
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, 32'h600, 3'd1, 0, 0, 0, 0, 32'h600);
    check("sat4_bc", {60'd0, branch_count_s}, 64'd15);
    check("bc20", {32'd0, branch_count}, 64'd20);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: ra = 32'd0;
        1: ra = 32'h8000_0000;
        2: ra = 32'hFFFF_FFFF;
        3: ra = 32'd5;
        default: ra = $urandom;
      endcase
      rb  = $urandom_range(0, 1) ? ra : $urandom;
      rpc = ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 8) | $urandom_range(0, 3);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, rpc,
           3'($urandom_range(0, 7)), ra, rb, 1'($urandom_range(0, 1)),
           $urandom_range(0, 29) == 0,
           ($urandom_range(0, 7) << 2) | ($urandom_range(0, 3) << 8));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
